pc_seq: RTL and testbench

Registered program-counter sequencer for the single-cycle datapath, generalising the combinational next-PC logic. It holds PC, computes the next word address from the branch, jump, call and return controls, and honours pipeline stalls. An optional return-address stack gives `jal`/`jr $ra` pairs a one-cycle target without a register-file read. It sits between the controller/ALU and the instruction memory address port.

---
 rtl/pc_seq.sv | 110 +++++++++++
 tb/tb_pc_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// Registered program-counter sequencer: branch/jump/call/return next-PC selection with stall hold.
// Optional return-address stack is compiled in by defining PC_SEQ_RAS_EN.
module pc_seq #(
  parameter int            AW        = 32,
  parameter int            IMM_W     = 16,
  parameter logic [AW-1:0] RESET_PC  = 1,
  parameter int            RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Br,
  input  logic             BrNe,
  input  logic             Zero,
  input  logic [IMM_W-1:0] Imm,
  input  logic             Jump,
  input  logic [25:0]      JTarget,
  input  logic             Call,
  input  logic             Ret,
  input  logic [AW-1:0]    JrTarget,
  output logic [AW-1:0]    PC,
  output logic [AW-1:0]    NPC,
  output logic             RasErr
);

  logic [AW-1:0] pcp1;
  logic [AW-1:0] imm_sext;
  logic [AW-1:0] jmp_tgt;
  logic [AW-1:0] ret_tgt;
  logic          br_taken;

  assign pcp1     = PC + 1'b1;
  assign imm_sext = AW'($signed(Imm));
  assign br_taken = Br & (Zero ^ BrNe);

  generate
    if (AW > 26) begin : g_jmp_wide
      assign jmp_tgt = {pcp1[AW-1:26], JTarget};
    end else begin : g_jmp_narrow
      assign jmp_tgt = JTarget[AW-1:0];
    end
  endgenerate

  always_comb begin
    NPC = pcp1;
    if (!Reset)        NPC = RESET_PC;
    else if (Ret)      NPC = ret_tgt;
    else if (Jump)     NPC = jmp_tgt;
    else if (br_taken) NPC = pcp1 + imm_sext;
  end

  always_ff @(posedge Clk) begin
    if (!Reset)      PC <= RESET_PC;
    else if (!Stall) PC <= NPC;
  end

`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_wr;
  logic [PW-1:0] ras_top;
  logic [CW-1:0] ras_cnt;
  logic          ras_empty;
  logic          ras_full;
  logic          do_push;
  logic          do_pop;
  logic          ras_err_q;

  // ras_wr points at the next free slot; when full it points at the oldest entry
  assign ras_top   = ras_wr - 1'b1;
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
  assign do_push   = Jump & Call & ~Ret;
  assign do_pop    = Ret;
  assign ret_tgt   = ras_empty ? JrTarget : ras_mem[ras_top];
  assign RasErr    = ras_err_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ras_wr    <= '0;
      ras_cnt   <= '0;
      ras_err_q <= 1'b0;
    end else if (Stall) begin
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= (do_push & ras_full) | (do_pop & ras_empty);
      if (do_push) begin
        ras_wr <= ras_wr + 1'b1;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (do_pop && !ras_empty) begin
        ras_wr  <= ras_top;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset && !Stall && do_push) ras_mem[ras_wr] <= pcp1;
  end
`else
  logic unused_call;

  assign unused_call = Call;
  assign ret_tgt     = JrTarget;
  assign RasErr      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq; expectations follow PC_SEQ_RAS_EN when it is defined.
module tb_pc_seq;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, Stall, Br, BrNe, Zero, Jump, Call, Ret;
  logic [15:0] Imm;
  logic [25:0] JTarget;
  logic [31:0] JrTarget;
  logic [31:0] PC, NPC;
  logic        RasErr;

  int checks   = 0;
  int failures = 0;

  pc_seq dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Br(Br), .BrNe(BrNe), .Zero(Zero),
    .Imm(Imm), .Jump(Jump), .JTarget(JTarget), .Call(Call), .Ret(Ret),
    .JrTarget(JrTarget), .PC(PC), .NPC(NPC), .RasErr(RasErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Stall = 1'b0; Br = 1'b0; BrNe = 1'b0; Zero = 1'b0;
    Jump = 1'b0; Call = 1'b0; Ret = 1'b0; Imm = '0; JTarget = '0; JrTarget = 32'd999;

    // reset and sequential fetch
    tick(); tick();
    chk("rst_pc", PC, 32'd1);
    chk("rst_err", {31'b0, RasErr}, 32'd0);
    chk("rst_npc", NPC, 32'd1);
    Reset = 1'b1; #1;
    chk("seq_npc", NPC, 32'd2);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("seq_pc", PC, 32'(i));
    end

    // branch sense at PC=10
    Jump = 1'b1; JTarget = 26'd10; tick(); Jump = 1'b0;
    chk("jmp_pc", PC, 32'd10);
    Br = 1'b1; BrNe = 1'b0; Zero = 1'b1; Imm = 16'hFFFD; #1;
    chk("beq_taken", NPC, 32'd8);
    Zero = 1'b0; #1;
    chk("beq_not", NPC, 32'd11);
    BrNe = 1'b1; Zero = 1'b1; #1;
    chk("bne_not", NPC, 32'd11);
    Zero = 1'b0; Imm = 16'd5; #1;
    chk("bne_taken", NPC, 32'd16);
    Jump = 1'b1; JTarget = 26'd40; #1;
    chk("jmp_over_br", NPC, 32'd40);
    Jump = 1'b0; #1;
    tick();
    chk("br_pc", PC, 32'd16);
    Br = 1'b0; BrNe = 1'b0;

    // stall hold
    Jump = 1'b1; JTarget = 26'd20; tick();
    chk("pre_stall_pc", PC, 32'd20);
    JTarget = 26'd100; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_npc", NPC, 32'd100);
      tick();
      chk("stall_pc", PC, 32'd20);
    end
    Stall = 1'b0; tick();
    chk("unstall_pc", PC, 32'd100);

    // wrap through all-ones
    JTarget = 26'd0; tick(); Jump = 1'b0;
    chk("zero_pc", PC, 32'd0);
    Br = 1'b1; Zero = 1'b1; Imm = 16'hFFFE; #1;
    chk("wrap_npc", NPC, 32'hFFFF_FFFF);
    tick(); Br = 1'b0; Zero = 1'b0; #1;
    chk("wrap_pc", PC, 32'hFFFF_FFFF);
    chk("wrap_npc0", NPC, 32'd0);
    tick();
    chk("wrap_pc0", PC, 32'd0);

    // Ret beats Jump+Call on an empty stack; no push happens
    Ret = 1'b1; Jump = 1'b1; Call = 1'b1; JTarget = 26'd7; #1;
    chk("ret_prio_npc", NPC, 32'd999);
    tick(); Ret = 1'b0; Jump = 1'b0; Call = 1'b0;
    chk("ret_prio_pc", PC, 32'd999);
    chk("ret_prio_err", {31'b0, RasErr}, 32'(RAS_ON));
    tick();
    chk("err_one_cycle", {31'b0, RasErr}, 32'd0);

    // Call without Jump pushes nothing
    Call = 1'b1; #1;
    chk("call_only_npc", NPC, 32'd1001);
    tick(); Call = 1'b0; Ret = 1'b1; #1;
    chk("call_only_ret", NPC, 32'd999);
    tick(); Ret = 1'b0;
    chk("call_only_err", {31'b0, RasErr}, 32'(RAS_ON));

    // call/return nesting
    Jump = 1'b1; JTarget = 26'd5; tick();
    chk("nest_start", PC, 32'd5);
    Call = 1'b1; JTarget = 26'd50; tick(); Jump = 1'b0; Call = 1'b0;
    chk("nest_jal1", PC, 32'd50);
    tick(); tick();
    chk("nest_52", PC, 32'd52);
    Jump = 1'b1; Call = 1'b1; JTarget = 26'd80; tick(); Jump = 1'b0; Call = 1'b0;
    chk("nest_jal2", PC, 32'd80);
    Ret = 1'b1; #1;
    chk("nest_ret1_npc", NPC, RAS_ON ? 32'd53 : 32'd999);
    tick();
    chk("nest_ret1_pc", PC, RAS_ON ? 32'd53 : 32'd999);
    chk("nest_ret1_err", {31'b0, RasErr}, 32'd0);
    tick(); Ret = 1'b0;
    chk("nest_ret2_pc", PC, RAS_ON ? 32'd6 : 32'd999);
    chk("nest_ret2_err", {31'b0, RasErr}, 32'd0);

    // stack limits: five pushes of 1..5 then five pops
    Jump = 1'b1; JTarget = 26'd0; tick();
    chk("lim_start", PC, 32'd0);
    Call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      JTarget = 26'(i); tick();
      chk("lim_push_pc", PC, 32'(i));
      chk("lim_push_err", {31'b0, RasErr}, 32'(RAS_ON && i == 5));
    end
    Jump = 1'b0; Call = 1'b0; Ret = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("lim_pop_npc", NPC, (RAS_ON && k < 4) ? 32'(5 - k) : 32'd999);
      tick();
      chk("lim_pop_err", {31'b0, RasErr}, 32'(RAS_ON && k == 4));
    end
    Ret = 1'b0; tick();
    chk("lim_err_clr", {31'b0, RasErr}, 32'd0);

    // reset mid-call sequence empties the stack
    Jump = 1'b1; Call = 1'b1; JTarget = 26'd30; tick();
    JTarget = 26'd31; tick(); Jump = 1'b0; Call = 1'b0;
    chk("mid_pc", PC, 32'd31);
    Reset = 1'b0; Stall = 1'b1; Ret = 1'b1; #1;
    chk("mid_rst_npc", NPC, 32'd1);
    tick();
    chk("mid_rst_pc", PC, 32'd1);
    chk("mid_rst_err", {31'b0, RasErr}, 32'd0);
    Reset = 1'b1; Stall = 1'b0; JrTarget = 32'd777; #1;
    chk("mid_ret_npc", NPC, 32'd777);
    tick();
    chk("mid_ret_pc", PC, 32'd777);
    chk("mid_ret_err", {31'b0, RasErr}, 32'(RAS_ON));

    // a stalled underflow does not commit or flag until released
    Stall = 1'b1; tick();
    chk("stall_err", {31'b0, RasErr}, 32'd0);
    chk("stall_ret_pc", PC, 32'd777);
    Stall = 1'b0; tick(); Ret = 1'b0;
    chk("release_err", {31'b0, RasErr}, 32'(RAS_ON));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
